// File: rtl/odo_work_rx.sv
// Framed byte receiver for miner work: A5 sync, 108 payload bytes, CRC-12 (0x80F),
// atomic header/target commit. Optional idle abandon via ODO_RX_TIMEOUT_EN.
module odo_work_rx #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [607:0] header,
  output logic [255:0] target,
  output logic         work_valid,
  output logic         crc_err,
  output logic         timeout,
  output logic [7:0]   err_count
);

  typedef enum logic [2:0] {HUNT, PAYLOAD, CRC_HI, CRC_LO, COMMIT} state_e;

  localparam logic [7:0] SYNC = 8'hA5;

  state_e         state_q;
  logic [6:0]     cnt_q;
  logic [11:0]    crc_q;
  logic [15:0]    rxcrc_q;
  logic [863:0]   stage_q;
  logic [607:0]   header_q;
  logic [255:0]   target_q;
  logic           work_valid_q, crc_err_q;
  logic [7:0]     err_q;
  logic           accept;

  // MSB-first, unreflected CRC-12 step over one byte
  function automatic logic [11:0] crc12_byte(input logic [11:0] c, input logic [7:0] b);
    logic [11:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[11] ^ b[i];
      r  = {r[10:0], 1'b0} ^ (fb ? 12'h80F : 12'h000);
    end
    return r;
  endfunction

  assign in_ready   = (state_q != COMMIT);
  assign accept     = in_valid && in_ready;
  assign header     = header_q;
  assign target     = target_q;
  assign work_valid = work_valid_q;
  assign crc_err    = crc_err_q;
  assign err_count  = err_q;

`ifdef ODO_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  // No idle tracking without the feature; the parameter is inert here.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      cnt_q        <= '0;
      crc_q        <= '0;
      rxcrc_q      <= '0;
      stage_q      <= '0;
      header_q     <= '0;
      target_q     <= '0;
      work_valid_q <= 1'b0;
      crc_err_q    <= 1'b0;
      err_q        <= '0;
`ifdef ODO_RX_TIMEOUT_EN
      idle_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      work_valid_q <= 1'b0;
      crc_err_q    <= 1'b0;
      case (state_q)
        HUNT: if (accept && in_data == SYNC) begin
          state_q <= PAYLOAD;
          cnt_q   <= '0;
          crc_q   <= '0;
        end
        PAYLOAD: if (accept) begin
          stage_q[int'(cnt_q)*8 +: 8] <= in_data;
          crc_q <= crc12_byte(crc_q, in_data);
          if (cnt_q == 7'd107) state_q <= CRC_HI;
          else                 cnt_q   <= cnt_q + 7'd1;
        end
        CRC_HI: if (accept) begin
          rxcrc_q[15:8] <= in_data;
          state_q       <= CRC_LO;
        end
        CRC_LO: if (accept) begin
          rxcrc_q[7:0] <= in_data;
          state_q      <= COMMIT;
        end
        COMMIT: begin
          // Upper nibble of CRC_HI must be zero, so compare all 16 bits
          if (rxcrc_q == {4'h0, crc_q}) begin
            header_q     <= stage_q[607:0];
            target_q     <= stage_q[863:608];
            work_valid_q <= 1'b1;
          end else begin
            crc_err_q <= 1'b1;
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          end
          state_q <= HUNT;
        end
        default: state_q <= HUNT;
      endcase
`ifdef ODO_RX_TIMEOUT_EN
      timeout_q <= 1'b0;
      if (state_q == PAYLOAD || state_q == CRC_HI || state_q == CRC_LO) begin
        if (accept) begin
          idle_q <= '0;
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
          idle_q    <= '0;
          state_q   <= HUNT;
          timeout_q <= 1'b1;
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end else begin
        idle_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_odo_work_rx.sv
// Directed bench for odo_work_rx: clean frames, CRC faults, garbage, mid-frame reset,
// and (with ODO_RX_TIMEOUT_EN) idle abandon at TIMEOUT_CYCLES = 16.
module tb_odo_work_rx;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [607:0] header;
  logic [255:0] target;
  logic         work_valid, crc_err, timeout;
  logic [7:0]   err_count;

  odo_work_rx #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .header(header), .target(target), .work_valid(work_valid), .crc_err(crc_err),
    .timeout(timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0, fails = 0;
  int wv_cnt = 0, ce_cnt = 0, to_cnt = 0, rl_cnt = 0;
  int wv0, ce0, to0, rl0;
  logic [7:0]   pl [108];
  logic [863:0] exp_stage;
  logic [11:0]  c;

  always @(negedge clk) if (!rst) begin
    if (work_valid) wv_cnt++;
    if (crc_err)    ce_cnt++;
    if (timeout)    to_cnt++;
    if (!in_ready)  rl_cnt++;
  end

  task automatic chk(input string tag, input logic [863:0] obs, input logic [863:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC by polynomial long division of payload * x^12 by 0x180F
  function automatic logic [11:0] model_crc();
    logic [12:0] r = '0;
    for (int k = 0; k < 108; k++)
      for (int i = 7; i >= 0; i--) begin
        r = {r[11:0], pl[k][i]};
        if (r[12]) r ^= 13'h180F;
      end
    for (int i = 0; i < 12; i++) begin
      r = {r[11:0], 1'b0};
      if (r[12]) r ^= 13'h180F;
    end
    return r[11:0];
  endfunction

  task automatic build_exp();
    for (int k = 0; k < 108; k++) exp_stage[k*8 +: 8] = pl[k];
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) chk("ready_wait", {863'd0, in_ready}, 864'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input int n);
    send_byte(8'hA5);
    for (int k = 0; k < n; k++) send_byte(pl[k]);
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo);
    send_payload(108);
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic snap();
    wv0 = wv_cnt; ce0 = ce_cnt; to0 = to_cnt; rl0 = rl_cnt;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_header", header, 864'd0);
    chk("rst_target", target, 864'd0);
    chk("rst_err", err_count, 864'd0);
    chk("rst_ready", in_ready, 864'd1);
    chk("rst_pulses", {work_valid, crc_err, timeout}, 864'd0);
    rst = 1'b0;

    // All-zero frame; CRC of zeros is zero
    for (int k = 0; k < 108; k++) pl[k] = 8'h00;
    snap();
    send_frame(8'h00, 8'h00);
    chk("commit_ready_low", in_ready, 864'd0);
    chk("commit_wv_not_yet", work_valid, 864'd0);
    @(posedge clk); #1;
    chk("commit_wv", work_valid, 864'd1);
    chk("commit_ready_back", in_ready, 864'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_wv_once", wv_cnt - wv0, 864'd1);
    chk("zero_ready_low_1", rl_cnt - rl0, 864'd1);
    chk("zero_header", header, 864'd0);
    chk("zero_err", err_count, 864'd0);

    // Payload k = k+1
    for (int k = 0; k < 108; k++) pl[k] = 8'(k + 1);
    build_exp();
    c = model_crc();
    snap();
    send_frame({4'h0, c[11:8]}, c[7:0]);
    repeat (3) @(posedge clk);
    #1;
    chk("inc_hdr_lsb", header[7:0], 864'h01);
    chk("inc_tgt_lsb", target[7:0], 864'h4D);
    chk("inc_tgt_msb", target[255:248], 864'h6C);
    chk("inc_header", header, exp_stage[607:0]);
    chk("inc_target", target, exp_stage[863:608]);
    chk("inc_wv_once", wv_cnt - wv0, 864'd1);

    // Two corrupted frames back to back (second one is offered during COMMIT)
    snap();
    send_frame({4'h0, c[11:8]}, c[7:0] ^ 8'h01);
    send_frame({4'h1, c[11:8]}, c[7:0]);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_crc_err2", ce_cnt - ce0, 864'd2);
    chk("bad_no_wv", wv_cnt - wv0, 864'd0);
    chk("bad_header_kept", header, exp_stage[607:0]);
    chk("bad_target_kept", target, exp_stage[863:608]);
    chk("bad_err_count", err_count, 864'd2);

    // Leading garbage and 0xA5 inside the payload
    pl[0] = 8'hA5; pl[10] = 8'hA5; pl[100] = 8'hA5;
    build_exp();
    c = model_crc();
    snap();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h00);
    send_frame({4'h0, c[11:8]}, c[7:0]);
    repeat (3) @(posedge clk);
    #1;
    chk("garb_header", header, exp_stage[607:0]);
    chk("garb_target", target, exp_stage[863:608]);
    chk("garb_wv_once", wv_cnt - wv0, 864'd1);

    // Reset after 50 payload bytes, then a full frame
    for (int k = 0; k < 108; k++) pl[k] = 8'(8'hF0 ^ k);
    build_exp();
    c = model_crc();
    send_payload(50);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_header", header, 864'd0);
    chk("mid_rst_target", target, 864'd0);
    chk("mid_rst_err", err_count, 864'd0);
    snap();
    send_frame({4'h0, c[11:8]}, c[7:0]);
    chk("post_rst_hdr_hold", header, 864'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_header", header, exp_stage[607:0]);
    chk("post_rst_target", target, exp_stage[863:608]);
    chk("post_rst_wv_once", wv_cnt - wv0, 864'd1);

`ifdef ODO_RX_TIMEOUT_EN
    // Stall after 20 payload bytes; frame must be abandoned
    snap();
    send_payload(20);
    repeat (40) @(posedge clk);
    #1;
    chk("to_pulse_once", to_cnt - to0, 864'd1);
    chk("to_err_count", err_count, 864'd1);
    chk("to_header_kept", header, exp_stage[607:0]);
    for (int k = 0; k < 108; k++) pl[k] = 8'(3 * k + 7);
    build_exp();
    c = model_crc();
    snap();
    send_frame({4'h0, c[11:8]}, c[7:0]);
    repeat (3) @(posedge clk);
    #1;
    chk("to_next_header", header, exp_stage[607:0]);
    chk("to_next_target", target, exp_stage[863:608]);
    chk("to_next_wv", wv_cnt - wv0, 864'd1);
`else
    // Without the feature a stalled frame just waits
    snap();
    send_payload(20);
    repeat (40) @(posedge clk);
    #1;
    chk("no_to_pulse", to_cnt - to0, 864'd0);
    chk("no_to_err", err_count, 864'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
